// File: rtl/ysyx_23060061_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory arbiter.
// FSM state encodings and master ids.
package ysyx_23060061_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ysyx_23060061_mem_arbiter_rr_arb2.sv
// Two-way round-robin grant.
// On a tie the master that did not win last time is chosen.
module ysyx_23060061_rr_arb2
  import ysyx_23060061_mem_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       idx
);

  // pick the sole requester, or alternate on a tie
  always_comb begin
    idx = M_IFU;
    case (valid)
      2'b01:   idx = M_IFU;
      2'b10:   idx = M_LSU;
      2'b11:   idx = ~last_grant;
      default: idx = M_IFU;
    endcase
    grant = (|valid) ? onehot2(idx) : 2'b00;
  end

endmodule

// File: rtl/ysyx_23060061_mem_arbiter.sv
// Shares one memory port between IFU (0) and LSU (1).
// One outstanding transaction, buffered response, optional timeout.
module ysyx_23060061_mem_arbiter
  import ysyx_23060061_mem_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    m_req_valid,
  output logic [1:0]    m_req_ready,
  input  logic [1:0]    m_req_wen,
  input  logic [2*AW-1:0] m_req_addr,
  input  logic [63:0]   m_req_wdata,
  input  logic [7:0]    m_req_wmask,
  output logic [1:0]    m_rsp_valid,
  input  logic [1:0]    m_rsp_ready,
  output logic [31:0]   m_rsp_rdata,
  output logic          m_rsp_err,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_req_wen,
  output logic [AW-1:0] mem_req_addr,
  output logic [31:0]   mem_req_wdata,
  output logic [3:0]    mem_req_wmask,
  input  logic          mem_rsp_valid,
  output logic          mem_rsp_ready,
  input  logic [31:0]   mem_rsp_rdata,
  input  logic          mem_rsp_err
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX =
    TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [TW-1:0] TFULL = '1;

  state_t          state, state_n;
  logic            g, last_grant;
  logic            wen;
  logic [AW-1:0]   addr;
  logic [31:0]     wdata, rdata;
  logic [3:0]      wmask;
  logic            err, stale;
  logic [TW-1:0]   timer;

  logic [1:0]      arb_grant;
  logic            arb_idx;
  logic            accept, issue_hs, rsp_hs, tmo, done;

  ysyx_23060061_rr_arb2 u_arb (
    .valid      (m_req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .idx        (arb_idx)
  );

  assign mem_req_wen   = wen;
  assign mem_req_addr  = addr;
  assign mem_req_wdata = wdata;
  assign mem_req_wmask = wen ? wmask : 4'b0000;
  assign m_rsp_rdata   = rdata;
  assign m_rsp_err     = err;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // next state and handshake outputs
  always_comb begin
    state_n       = state;
    m_req_ready   = 2'b00;
    m_rsp_valid   = 2'b00;
    mem_req_valid = 1'b0;
    mem_rsp_ready = stale;
    accept        = 1'b0;
    issue_hs      = 1'b0;
    rsp_hs        = 1'b0;
    tmo           = 1'b0;
    done          = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if ((|m_req_valid) && !rst) begin
          m_req_ready = arb_grant;
          accept      = 1'b1;
          state_n     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!stale) begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) begin
            issue_hs = 1'b1;
            state_n  = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        mem_rsp_ready = 1'b1;
        if (mem_rsp_valid) begin
          rsp_hs  = 1'b1;
          state_n = ST_RESP;
        end else if (TIMEOUT != 0 && timer == TMAX) begin
          tmo     = 1'b1;
          state_n = ST_RESP;
        end
      end
      ST_RESP: begin
        m_rsp_valid = onehot2(g);
        if (m_rsp_ready[g]) begin
          done    = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // request latch, response buffer, timer and stale tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g          <= M_IFU;
      last_grant <= M_LSU;
      wen        <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      wmask      <= '0;
      rdata      <= '0;
      err        <= 1'b0;
      stale      <= 1'b0;
      timer      <= '0;
    end else begin
      if (accept) begin
        g     <= arb_idx;
        wen   <= m_req_wen[arb_idx];
        addr  <= m_req_addr[arb_idx*AW +: AW];
        wdata <= m_req_wdata[arb_idx*32 +: 32];
        wmask <= m_req_wmask[arb_idx*4 +: 4];
      end
      if (issue_hs) begin
        timer <= '0;
      end else if (state == ST_WAIT && !mem_rsp_valid
                   && timer != TFULL) begin
        timer <= timer + 1'b1;
      end
      if (rsp_hs) begin
        rdata <= wen ? 32'h0 : mem_rsp_rdata;
        err   <= mem_rsp_err;
      end
      if (tmo) begin
        rdata <= 32'h0;
        err   <= 1'b1;
        stale <= 1'b1;
      end else if (stale && mem_rsp_valid) begin
        stale <= 1'b0;
      end
      if (done) last_grant <= g;
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter.
// Uses a small one-cycle memory model with stall/no-response knobs.
module tb_ysyx_23060061_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  m_req_valid = '0;
  logic [1:0]  m_req_ready;
  logic [1:0]  m_req_wen = '0;
  logic [63:0] m_req_addr = '0;
  logic [63:0] m_req_wdata = '0;
  logic [7:0]  m_req_wmask = '0;
  logic [1:0]  m_rsp_valid;
  logic [1:0]  m_rsp_ready = 2'b11;
  logic [31:0] m_rsp_rdata;
  logic        m_rsp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic        mem_rsp_ready;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;

  logic        ready_en = 1'b1;
  logic        rsp_en = 1'b1;
  logic        pend;
  logic [31:0] mem_data = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_23060061_mem_arbiter #(.AW(32), .TIMEOUT(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .m_req_valid   (m_req_valid),
    .m_req_ready   (m_req_ready),
    .m_req_wen     (m_req_wen),
    .m_req_addr    (m_req_addr),
    .m_req_wdata   (m_req_wdata),
    .m_req_wmask   (m_req_wmask),
    .m_rsp_valid   (m_rsp_valid),
    .m_rsp_ready   (m_rsp_ready),
    .m_rsp_rdata   (m_rsp_rdata),
    .m_rsp_err     (m_rsp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_wen   (mem_req_wen),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wmask (mem_req_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_ready (mem_rsp_ready),
    .mem_rsp_rdata (mem_rsp_rdata),
    .mem_rsp_err   (mem_rsp_err)
  );

  assign mem_req_ready = ready_en;
  assign mem_rsp_valid = pend && rsp_en;
  assign mem_rsp_rdata = mem_data;
  assign mem_rsp_err   = 1'b0;

  // memory answers one cycle after each accepted request
  always @(posedge clk or posedge rst) begin
    if (rst) pend <= 1'b0;
    else begin
      if (mem_rsp_valid && mem_rsp_ready) pend <= 1'b0;
      if (mem_req_valid && mem_req_ready) pend <= 1'b1;
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (m_req_ready !== 2'b00) begin
      failures++; $display("FAIL reset_req_ready got=%b exp=00", m_req_ready);
    end
    checks++;
    if (m_rsp_valid !== 2'b00) begin
      failures++; $display("FAIL reset_rsp_valid got=%b exp=00", m_rsp_valid);
    end
    checks++;
    if ({mem_req_valid, mem_rsp_ready, mem_req_wen} !== 3'b000) begin
      failures++;
      $display("FAIL reset_mem_ctl got=%b%b%b exp=000",
               mem_req_valid, mem_rsp_ready, mem_req_wen);
    end
    checks++;
    if ({mem_req_addr, mem_req_wdata, mem_req_wmask} !== 68'h0) begin
      failures++;
      $display("FAIL reset_mem_data got=%h %h %h exp=0",
               mem_req_addr, mem_req_wdata, mem_req_wmask);
    end
  endtask

  task automatic test_ifu_read();
    mem_data = 32'hDEADBEEF;
    @(negedge clk);
    m_req_valid = 2'b01;
    m_req_wen   = 2'b00;
    m_req_addr  = {32'h12340000, 32'h80000000};
    m_req_wmask = 8'hFF;
    #1;
    checks++;
    if (m_req_ready !== 2'b01) begin
      failures++; $display("FAIL ifu_accept got=%b exp=01", m_req_ready);
    end
    @(negedge clk);
    m_req_valid = 2'b00;
    m_rsp_ready = 2'b00;
    #1;
    checks++;
    if ({mem_req_valid, mem_req_wen, mem_req_wmask} !== 6'b100000) begin
      failures++;
      $display("FAIL ifu_issue got=%b %b %b exp=1 0 0000",
               mem_req_valid, mem_req_wen, mem_req_wmask);
    end
    checks++;
    if (mem_req_addr !== 32'h80000000) begin
      failures++; $display("FAIL ifu_addr got=%h exp=80000000", mem_req_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (m_rsp_valid !== 2'b00) begin
      failures++; $display("FAIL ifu_early_rsp got=%b exp=00", m_rsp_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (m_rsp_valid !== 2'b01) begin
      failures++; $display("FAIL ifu_rsp_valid got=%b exp=01", m_rsp_valid);
    end
    checks++;
    if ({m_rsp_rdata, m_rsp_err} !== {32'hDEADBEEF, 1'b0}) begin
      failures++;
      $display("FAIL ifu_rsp_data got=%h/%b exp=deadbeef/0",
               m_rsp_rdata, m_rsp_err);
    end
    @(negedge clk); #1;
    checks++;
    if (m_rsp_valid !== 2'b01) begin
      failures++; $display("FAIL ifu_rsp_hold got=%b exp=01", m_rsp_valid);
    end
    m_rsp_ready = 2'b11;
    @(negedge clk); #1;
    checks++;
    if (m_rsp_valid !== 2'b00) begin
      failures++; $display("FAIL ifu_rsp_drop got=%b exp=00", m_rsp_valid);
    end
  endtask

  task automatic test_lsu_write();
    mem_data = 32'hCAFEF00D;
    @(negedge clk);
    m_req_valid = 2'b10;
    m_req_wen   = 2'b10;
    m_req_addr  = {32'h80000100, 32'h11111110};
    m_req_wdata = {32'h12345678, 32'hAAAAAAAA};
    m_req_wmask = {4'b0011, 4'b1111};
    #1;
    checks++;
    if (m_req_ready !== 2'b10) begin
      failures++; $display("FAIL lsu_accept got=%b exp=10", m_req_ready);
    end
    @(negedge clk);
    m_req_valid = 2'b00;
    #1;
    checks++;
    if ({mem_req_valid, mem_req_wen, mem_req_wmask} !== 6'b110011) begin
      failures++;
      $display("FAIL lsu_issue got=%b %b %b exp=1 1 0011",
               mem_req_valid, mem_req_wen, mem_req_wmask);
    end
    checks++;
    if ({mem_req_addr, mem_req_wdata} !== {32'h80000100, 32'h12345678}) begin
      failures++;
      $display("FAIL lsu_addr_data got=%h %h exp=80000100 12345678",
               mem_req_addr, mem_req_wdata);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({m_rsp_valid, m_rsp_rdata, m_rsp_err} !== {2'b10, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL lsu_rsp got=%b %h %b exp=10 00000000 0",
               m_rsp_valid, m_rsp_rdata, m_rsp_err);
    end
    m_req_wen = 2'b00;
  endtask

  task automatic test_stall();
    logic [31:0] a0;
    mem_data = 32'h0BADF00D;
    ready_en = 1'b0;
    @(negedge clk);
    m_req_valid = 2'b01;
    m_req_addr  = {32'h0, 32'h80000040};
    #1;
    checks++;
    if (m_req_ready !== 2'b01) begin
      failures++; $display("FAIL stall_accept got=%b exp=01", m_req_ready);
    end
    a0 = 32'h80000040;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m_req_valid = 2'b00;
      m_req_addr  = {32'h0, 32'h0000DEAD};
      #1;
      checks++;
      if ({mem_req_valid, mem_req_addr, mem_req_wen} !== {1'b1, a0, 1'b0}) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got=%b %h exp=1 %h",
                 i, mem_req_valid, mem_req_addr, a0);
      end
    end
    ready_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({m_rsp_valid, m_rsp_rdata, m_rsp_err} !== {2'b01, 32'h0BADF00D, 1'b0}) begin
      failures++;
      $display("FAIL stall_rsp got=%b %h %b exp=01 0badf00d 0",
               m_rsp_valid, m_rsp_rdata, m_rsp_err);
    end
  endtask

  task automatic test_timeout();
    mem_data = 32'h55AA55AA;
    rsp_en   = 1'b0;
    @(negedge clk);
    m_req_valid = 2'b01;
    m_req_addr  = {32'h0, 32'h80000080};
    @(negedge clk);
    m_req_valid = 2'b00;
    repeat (8) @(negedge clk);
    #1;
    checks++;
    if (m_rsp_valid !== 2'b00) begin
      failures++; $display("FAIL tmo_early got=%b exp=00", m_rsp_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({m_rsp_valid, m_rsp_rdata, m_rsp_err} !== {2'b01, 32'h0, 1'b1}) begin
      failures++;
      $display("FAIL tmo_rsp got=%b %h %b exp=01 00000000 1",
               m_rsp_valid, m_rsp_rdata, m_rsp_err);
    end
    checks++;
    if (mem_rsp_ready !== 1'b1) begin
      failures++; $display("FAIL tmo_drain_ready got=%b exp=1", mem_rsp_ready);
    end
    m_req_valid = 2'b10;
    m_req_addr  = {32'h80000200, 32'h0};
    @(negedge clk);
    #1;
    checks++;
    if (m_req_ready !== 2'b10) begin
      failures++; $display("FAIL tmo_next_accept got=%b exp=10", m_req_ready);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      m_req_valid = 2'b00;
      #1;
      checks++;
      if (mem_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL tmo_stale_block cyc=%0d got=%b exp=0", i, mem_req_valid);
      end
    end
    rsp_en = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h80000200}) begin
      failures++;
      $display("FAIL tmo_after_drain got=%b %h exp=1 80000200",
               mem_req_valid, mem_req_addr);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({m_rsp_valid, m_rsp_rdata, m_rsp_err} !== {2'b10, 32'h55AA55AA, 1'b0}) begin
      failures++;
      $display("FAIL tmo_next_rsp got=%b %h %b exp=10 55aa55aa 0",
               m_rsp_valid, m_rsp_rdata, m_rsp_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_seq [4];
    int k;
    exp_seq[0] = 2'b01;
    exp_seq[1] = 2'b10;
    exp_seq[2] = 2'b01;
    exp_seq[3] = 2'b10;
    k = 0;
    mem_data = 32'h00C0FFEE;
    @(negedge clk);
    apply_reset();
    m_req_valid = 2'b11;
    m_req_addr  = {32'h80000400, 32'h80000000};
    for (int c = 0; c < 40 && k < 4; c++) begin
      #1;
      checks++;
      if (m_req_ready === 2'b11) begin
        failures++; $display("FAIL b2b_onehot cyc=%0d got=%b", c, m_req_ready);
      end
      if (m_req_ready !== 2'b00) begin
        checks++;
        if (m_req_ready !== exp_seq[k]) begin
          failures++;
          $display("FAIL b2b_grant n=%0d got=%b exp=%b",
                   k, m_req_ready, exp_seq[k]);
        end
        k++;
      end
      if (k < 4) @(negedge clk);
    end
    checks++;
    if (k != 4) begin
      failures++; $display("FAIL b2b_count got=%0d exp=4", k);
    end
    @(negedge clk);
    m_req_valid = 2'b00;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    rsp_en = 1'b0;
    @(negedge clk);
    m_req_valid = 2'b01;
    m_req_addr  = {32'h0, 32'h80000300};
    @(negedge clk);
    m_req_valid = 2'b00;
    @(negedge clk);
    #1;
    checks++;
    if (mem_rsp_ready !== 1'b1) begin
      failures++; $display("FAIL rstw_in_wait got=%b exp=1", mem_rsp_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    m_req_valid = 2'b01;
    #1;
    checks++;
    if ({m_req_ready, m_rsp_valid, mem_req_valid, mem_rsp_ready} !== 6'b0) begin
      failures++;
      $display("FAIL rstw_ctl got=%b %b %b %b exp=00 00 0 0",
               m_req_ready, m_rsp_valid, mem_req_valid, mem_rsp_ready);
    end
    checks++;
    if ({mem_req_addr, mem_req_wdata, mem_req_wmask,
         m_rsp_rdata, m_rsp_err} !== 101'h0) begin
      failures++;
      $display("FAIL rstw_data got=%h %h %h %h %b exp=0",
               mem_req_addr, mem_req_wdata, mem_req_wmask,
               m_rsp_rdata, m_rsp_err);
    end
    @(negedge clk);
    rst = 1'b0;
    m_req_valid = 2'b00;
    rsp_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({m_rsp_valid, mem_req_valid} !== 3'b000) begin
        failures++;
        $display("FAIL rstw_quiet cyc=%0d got=%b %b exp=00 0",
                 i, m_rsp_valid, mem_req_valid);
      end
    end
    m_req_valid = 2'b01;
    #1;
    checks++;
    if (m_req_ready !== 2'b01) begin
      failures++; $display("FAIL rstw_idle_accept got=%b exp=01", m_req_ready);
    end
    @(negedge clk);
    m_req_valid = 2'b00;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_stall();
    test_timeout();
    test_back_to_back();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
